bitstream_refill: RTL and testbench

BITSTREAM_REFILL -- requirements
Module: bitstream_refill

---
 rtl/bitstream_refill_pkg.sv | 15 +
 rtl/bitstream_refill_window_shifter.sv | 34 +++
 rtl/bitstream_refill.sv | 121 ++++++++++++
 tb/tb_bitstream_refill.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/bitstream_refill_pkg.sv
// Shared definitions for the bitstream refill block: FSM encoding, pad byte, maximum renormalisation shift.
package bitstream_refill_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    PAD   = 2'd3
  } state_t;

  // Stored form of a zero pad byte after the inversion applied to every inserted byte.
  localparam logic [7:0] PAD_BYTE  = 8'hFF;
  localparam int         MAX_SHIFT = 16;

endpackage

// File: rtl/bitstream_refill_window_shifter.sv
// Combinational window datapath: left shift with zero fill, then MSB-aligned byte insert below the remaining bits.
module window_shifter #(
  parameter int WIN_W  = 32,
  parameter int BYTE_W = 8,
  parameter int D_SIZE = 5,
  parameter int CNT_W  = $clog2(WIN_W + 1)
) (
  input  logic [WIN_W-1:0]  win,
  input  logic [CNT_W-1:0]  cnt,
  input  logic [D_SIZE-1:0] amt,
  input  logic [BYTE_W-1:0] ins_byte,
  input  logic              insert_en,
  output logic [WIN_W-1:0]  win_next,
  output logic [CNT_W-1:0]  cnt_next
);

  logic [WIN_W-1:0] shifted;
  logic [WIN_W-1:0] placed;
  logic [CNT_W-1:0] cnt_shifted;

  // Bits below the valid count are always zero, so the insert can simply be OR-ed in.
  always_comb begin
    shifted     = win << amt;
    cnt_shifted = cnt - CNT_W'(amt);
    placed      = {ins_byte, {(WIN_W-BYTE_W){1'b0}}} >> cnt_shifted;
    win_next    = shifted;
    cnt_next    = cnt_shifted;
    if (insert_en) begin
      win_next = shifted | placed;
      cnt_next = cnt_shifted + CNT_W'(BYTE_W);
    end
  end

endmodule

// File: rtl/bitstream_refill.sv
// Byte-to-window refill for an arithmetic decoder core, with end-of-frame padding of inverted zeros.
// Optional BR_OVERRUN_CHECK_EN tracks real stream bits and flags over-consumption while padding.
module bitstream_refill
  import bitstream_refill_pkg::*;
#(
  parameter int S1_WIN_WIDTH   = 32,
  parameter int S1_BYTE_WIDTH  = 8,
  parameter int S1_RANGE_WIDTH = 16,
  parameter int S1_D_SIZE      = 5
) (
  input  logic                      s1_clk,
  input  logic                      s1_reset,
  input  logic                      s1_flag_first,
  input  logic [S1_BYTE_WIDTH-1:0]  in_byte,
  input  logic                      in_byte_valid,
  input  logic                      in_byte_last,
  output logic                      out_byte_ready,
  input  logic                      in_shift_req,
  input  logic [S1_D_SIZE-1:0]      in_shift_amt,
  output logic [S1_RANGE_WIDTH-1:0] out_window,
  output logic                      out_window_valid,
  output logic                      out_flag_pad,
  output logic                      out_overrun
);

  localparam int CW = $clog2(S1_WIN_WIDTH + 1);
  localparam logic [CW-1:0] CNT_ROOM  = CW'(S1_WIN_WIDTH - S1_BYTE_WIDTH);
  localparam logic [CW-1:0] CNT_VALID = CW'(MAX_SHIFT);

  state_t                     state, state_n;
  logic [S1_WIN_WIDTH-1:0]    win, win_n;
  logic [CW-1:0]              cnt, cnt_n;
  logic                       shift_en, sat, byte_acc, pad_ins, ins_en, ovr_set;
  logic [S1_D_SIZE-1:0]       amt;
  logic [S1_BYTE_WIDTH-1:0]   ins_dat;

  always_comb begin
    shift_en = in_shift_req && out_window_valid && (state == RUN || state == PAD);
    sat      = int'(in_shift_amt) > int'(cnt);
    amt      = '0;
    if (shift_en) amt = sat ? S1_D_SIZE'(cnt) : in_shift_amt;
    byte_acc = in_byte_valid && out_byte_ready;
    pad_ins  = (state == PAD) && (cnt <= CNT_ROOM);
    ins_en   = byte_acc || pad_ins;
    ins_dat  = pad_ins ? S1_BYTE_WIDTH'(PAD_BYTE) : ~in_byte;
  end

  window_shifter #(
    .WIN_W  (S1_WIN_WIDTH),
    .BYTE_W (S1_BYTE_WIDTH),
    .D_SIZE (S1_D_SIZE),
    .CNT_W  (CW)
  ) u_shifter (
    .win       (win),
    .cnt       (cnt),
    .amt       (amt),
    .ins_byte  (ins_dat),
    .insert_en (ins_en),
    .win_next  (win_n),
    .cnt_next  (cnt_n)
  );

  // A last byte taken while still priming goes straight to padding.
  always_comb begin
    state_n = state;
    case (state)
      PRIME:   if (byte_acc && in_byte_last) state_n = PAD;
               else if (cnt_n >= CNT_VALID)  state_n = RUN;
      RUN:     if (byte_acc && in_byte_last) state_n = PAD;
      default: state_n = state;
    endcase
  end

`ifdef BR_OVERRUN_CHECK_EN
  logic [CW-1:0] real_cnt, real_dec;

  always_comb begin
    real_dec = (real_cnt > CW'(amt)) ? real_cnt - CW'(amt) : '0;
    ovr_set  = shift_en && (sat || (state == PAD && int'(in_shift_amt) > int'(real_cnt)));
  end

  always_ff @(posedge s1_clk or negedge s1_reset) begin
    if (!s1_reset)          real_cnt <= '0;
    else if (s1_flag_first) real_cnt <= '0;
    else                    real_cnt <= real_dec + (byte_acc ? CW'(S1_BYTE_WIDTH) : CW'(0));
  end
`else
  always_comb ovr_set = shift_en && sat;
`endif

  always_ff @(posedge s1_clk or negedge s1_reset) begin
    if (!s1_reset) begin
      state            <= IDLE;
      win              <= '0;
      cnt              <= '0;
      out_byte_ready   <= 1'b0;
      out_window_valid <= 1'b0;
      out_flag_pad     <= 1'b0;
      out_overrun      <= 1'b0;
    end else if (s1_flag_first) begin
      state            <= PRIME;
      win              <= '0;
      cnt              <= '0;
      out_byte_ready   <= 1'b1;
      out_window_valid <= 1'b0;
      out_flag_pad     <= 1'b0;
      out_overrun      <= 1'b0;
    end else begin
      state            <= state_n;
      win              <= win_n;
      cnt              <= cnt_n;
      out_byte_ready   <= (state_n == PRIME || state_n == RUN) && (cnt_n <= CNT_ROOM);
      out_window_valid <= (cnt_n >= CNT_VALID) && (state_n == RUN || state_n == PAD);
      out_flag_pad     <= (state_n == PAD);
      out_overrun      <= out_overrun || ovr_set;
    end
  end

  assign out_window = win[S1_WIN_WIDTH-1 -: S1_RANGE_WIDTH];

endmodule

// File: tb/tb_bitstream_refill.sv
// Directed bench for bitstream_refill with an expected-output queue; overrun expectation follows BR_OVERRUN_CHECK_EN.
module tb_bitstream_refill;

  logic        s1_clk = 1'b0;
  logic        s1_reset;
  logic        s1_flag_first;
  logic [7:0]  in_byte;
  logic        in_byte_valid;
  logic        in_byte_last;
  logic        out_byte_ready;
  logic        in_shift_req;
  logic [4:0]  in_shift_amt;
  logic [15:0] out_window;
  logic        out_window_valid;
  logic        out_flag_pad;
  logic        out_overrun;

`ifdef BR_OVERRUN_CHECK_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  typedef struct {
    string       tag;
    logic [15:0] win;
    logic        vld;
    logic        rdy;
    logic        pad;
    logic        ovr;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  bitstream_refill dut (
    .s1_clk           (s1_clk),
    .s1_reset         (s1_reset),
    .s1_flag_first    (s1_flag_first),
    .in_byte          (in_byte),
    .in_byte_valid    (in_byte_valid),
    .in_byte_last     (in_byte_last),
    .out_byte_ready   (out_byte_ready),
    .in_shift_req     (in_shift_req),
    .in_shift_amt     (in_shift_amt),
    .out_window       (out_window),
    .out_window_valid (out_window_valid),
    .out_flag_pad     (out_flag_pad),
    .out_overrun      (out_overrun)
  );

  always #5 s1_clk = ~s1_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [15:0] w, input logic v, input logic r,
                      input logic p, input logic o);
    exp_t e;
    e.tag = tag; e.win = w; e.vld = v; e.rdy = r; e.pad = p; e.ovr = o;
    exp_q.push_back(e);
  endtask

  task automatic check_front();
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("queue_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk({e.tag, "_win"}, {16'd0, out_window}, {16'd0, e.win});
      chk({e.tag, "_vld"}, {31'd0, out_window_valid}, {31'd0, e.vld});
      chk({e.tag, "_rdy"}, {31'd0, out_byte_ready}, {31'd0, e.rdy});
      chk({e.tag, "_pad"}, {31'd0, out_flag_pad}, {31'd0, e.pad});
      chk({e.tag, "_ovr"}, {31'd0, out_overrun}, {31'd0, e.ovr});
    end
  endtask

  task automatic tick();
    @(posedge s1_clk);
    #1;
  endtask

  task automatic step(input string tag, input logic [15:0] w, input logic v, input logic r,
                      input logic p, input logic o);
    push(tag, w, v, r, p, o);
    tick();
    check_front();
  endtask

  task automatic idle_in();
    s1_flag_first = 0; in_byte_valid = 0; in_byte_last = 0; in_byte = 8'h00;
    in_shift_req = 0; in_shift_amt = 5'd0;
  endtask

  initial begin
    s1_reset = 1'b0;
    idle_in();
    #1;
    push("reset", 16'h0000, 0, 0, 0, 0);
    check_front();
    tick(); tick();
    s1_reset = 1'b1;
    step("idle", 16'h0000, 0, 0, 0, 0);

    // Frame 1: prime with 0x12, 0x34
    s1_flag_first = 1;
    step("first", 16'h0000, 0, 1, 0, 0);
    s1_flag_first = 0;
    in_byte_valid = 1; in_byte = 8'h12;
    step("b12", 16'hED00, 0, 1, 0, 0);
    in_byte = 8'h34;
    step("b34", 16'hEDCB, 1, 1, 0, 0);

    // Shift 4 together with 0x56
    in_byte = 8'h56; in_shift_req = 1; in_shift_amt = 5'd4;
    step("sh4_b56", 16'hDCBA, 1, 1, 0, 0);
    in_shift_req = 0;

    // Held valid: 0x01 fills to 28, 0x02 must be refused
    in_byte = 8'h01;
    step("b01", 16'hDCBA, 1, 0, 0, 0);
    in_byte = 8'h02;
    step("b02_refused", 16'hDCBA, 1, 0, 0, 0);
    in_byte_valid = 0;

    in_shift_req = 1; in_shift_amt = 5'd16;
    step("sh16_run", 16'h9FE0, 0, 1, 0, 0);
    in_shift_req = 0;

    // Last byte enters PAD
    in_byte_valid = 1; in_byte_last = 1; in_byte = 8'hA5;
    step("last_a5", 16'h9FE5, 1, 0, 1, 0);
    in_byte_valid = 0; in_byte_last = 0;
    step("pad_fill1", 16'h9FE5, 1, 0, 1, 0);
    in_shift_req = 1; in_shift_amt = 5'd16;
    step("pad_sh16", 16'hAFF0, 0, 0, 1, 0);
    in_shift_req = 0;
    step("pad_fill2", 16'hAFFF, 1, 0, 1, 0);
    step("pad_fill3", 16'hAFFF, 1, 0, 1, 0);

    // Four real bits remain; shifting 8 over-consumes
    in_shift_req = 1; in_shift_amt = 5'd8;
    step("pad_sh8", 16'hFFFF, 1, 0, 1, OVR_EN);
    in_shift_req = 0;
    step("ovr_sticky", 16'hFFFF, 1, 0, 1, OVR_EN);

    s1_flag_first = 1;
    step("restart", 16'h0000, 0, 1, 0, 0);
    s1_flag_first = 0;

    // Frame 2: continuous valid, exactly four bytes accepted
    in_byte_valid = 1; in_byte = 8'h11;
    step("h11", 16'hEE00, 0, 1, 0, 0);
    in_byte = 8'h22;
    step("h22", 16'hEEDD, 1, 1, 0, 0);
    in_byte = 8'h33;
    step("h33", 16'hEEDD, 1, 1, 0, 0);
    in_byte = 8'h44;
    step("h44_full", 16'hEEDD, 1, 0, 0, 0);
    in_byte = 8'h55;
    step("h55_refused", 16'hEEDD, 1, 0, 0, 0);
    in_byte_valid = 0;
    in_shift_req = 1; in_shift_amt = 5'd16;
    step("h_sh16a", 16'hCCBB, 1, 1, 0, 0);
    step("h_sh16b", 16'h0000, 0, 1, 0, 0);
    in_shift_req = 0;

    // Async reset mid-RUN with a byte on the bus
    in_byte_valid = 1; in_byte = 8'h77;
    step("b77", 16'h8800, 0, 1, 0, 0);
    in_byte = 8'h99;
    #3;
    s1_reset = 1'b0;
    #1;
    push("async_rst", 16'h0000, 0, 0, 0, 0);
    check_front();
    tick();
    idle_in();
    s1_reset = 1'b1;
    step("post_rst_idle", 16'h0000, 0, 0, 0, 0);

    s1_flag_first = 1;
    step("first2", 16'h0000, 0, 1, 0, 0);
    s1_flag_first = 0;
    in_byte_valid = 1; in_byte = 8'h12;
    step("r12", 16'hED00, 0, 1, 0, 0);
    in_byte = 8'h34;
    step("r34", 16'hEDCB, 1, 1, 0, 0);
    in_byte_valid = 0;

    // Shift beyond the valid count saturates and flags overrun
    in_shift_req = 1; in_shift_amt = 5'd20;
    step("sat_sh20", 16'h0000, 0, 1, 0, 1);
    in_shift_req = 0;
    step("sat_sticky", 16'h0000, 0, 1, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
